cache_assoc_param: RTL and testbench

//  Parametrised N-way set-associative cache array; successor to the fixed 2-way/32-set array.

---
 rtl/cache_assoc_param_pkg.sv | 35 +++
 rtl/cache_assoc_param_if.sv | 35 +++
 rtl/cache_assoc_param_lru_age_set.sv | 49 ++++
 rtl/cache_assoc_param.sv | 168 ++++++++++++++++
 tb/tb_cache_assoc_param.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/cache_assoc_param_pkg.sv
// Shared types and helpers for the parametrised set-associative cache array.
// Holds address-field width math, load/store size encodings and the sweep FSM state.
package cache_assoc_param_pkg;

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  // Bit positions inside u_b_h_w: byte access when neither size bit is set.
  localparam int unsigned UbhwHalf = 0;
  localparam int unsigned UbhwWord = 1;
  localparam int unsigned UbhwUns  = 2;

  function automatic int unsigned tag_width(int unsigned addr_bits, int unsigned sets,
                                            int unsigned block_words);
    return addr_bits - $clog2(sets) - $clog2(block_words) - 2;
  endfunction

  function automatic logic [31:0] load_extract(logic [31:0] w, logic [1:0] boff,
                                               logic [2:0] ubhw);
    logic [31:0] sh;
    sh = w >> {boff, 3'b000};
    if (ubhw[UbhwWord]) return w;
    if (ubhw[UbhwHalf]) return ubhw[UbhwUns] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    return ubhw[UbhwUns] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
  endfunction

  function automatic logic [31:0] store_merge(logic [31:0] old, logic [31:0] din,
                                              logic [1:0] boff, logic [2:0] ubhw);
    logic [31:0] mask;
    if (ubhw[UbhwWord])      mask = 32'hFFFF_FFFF;
    else if (ubhw[UbhwHalf]) mask = 32'h0000_FFFF << {boff, 3'b000};
    else                     mask = 32'h0000_00FF << {boff, 3'b000};
    return (old & ~mask) | ((din << {boff, 3'b000}) & mask);
  endfunction

endpackage

// File: rtl/cache_assoc_param_if.sv
// Command/status bundle between the cache controller and the cache array.
interface cache_assoc_param_if #(
  parameter int unsigned ADDR_BITS   = 32,
  parameter int unsigned SETS        = 32,
  parameter int unsigned BLOCK_WORDS = 4
);
  localparam int unsigned TAG_W = cache_assoc_param_pkg::tag_width(ADDR_BITS, SETS, BLOCK_WORDS);

  logic [ADDR_BITS-1:0] addr;
  logic                 load;
  logic                 edit;
  logic                 store;
  logic                 evict;
  logic                 invalid;
  logic                 flush_all;
  logic [2:0]           u_b_h_w;
  logic [31:0]          din;
  logic                 hit;
  logic [31:0]          dout;
  logic                 valid;
  logic                 dirty;
  logic [TAG_W-1:0]     tag;
  logic                 fill_done;
  logic                 busy;

  modport master (
    output addr, load, edit, store, evict, invalid, flush_all, u_b_h_w, din,
    input  hit, dout, valid, dirty, tag, fill_done, busy
  );

  modport slave (
    input  addr, load, edit, store, evict, invalid, flush_all, u_b_h_w, din,
    output hit, dout, valid, dirty, tag, fill_done, busy
  );
endinterface

// File: rtl/cache_assoc_param_lru_age_set.sv
// True-LRU age vector for one set: registered ages, combinational victim choice.
module cache_assoc_param_lru_age_set #(
  parameter int unsigned WAYS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WAYS-1:0]          valid_i,
  input  logic                     touch_i,
  input  logic [$clog2(WAYS)-1:0]  touch_way_i,
  output logic [$clog2(WAYS)-1:0]  victim_o
);
  localparam int unsigned AGE_W = $clog2(WAYS);

  // Ages are stored XOR way index, so a cleared set is the identity permutation.
  logic [AGE_W-1:0] enc_q [WAYS];
  logic [AGE_W-1:0] age   [WAYS];
  logic [AGE_W-1:0] age_h;
  logic             inv_found;

  always_comb begin
    for (int w = 0; w < WAYS; w++) age[w] = enc_q[w] ^ AGE_W'(w);
    age_h = age[touch_way_i];
  end

  always_comb begin
    victim_o  = '0;
    inv_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (age[w] == AGE_W'(WAYS - 1)) victim_o = AGE_W'(w);
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_i[w] && !inv_found) begin
        victim_o  = AGE_W'(w);
        inv_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) enc_q[w] <= '0;
    end else if (touch_i) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == touch_way_i)  enc_q[w] <= AGE_W'(w);
        else if (age[w] < age_h)       enc_q[w] <= (age[w] + AGE_W'(1)) ^ AGE_W'(w);
      end
    end
  end
endmodule

// File: rtl/cache_assoc_param.sv
// N-way set-associative cache array with LRU, sequenced block refill and flush sweep.
module cache_assoc_param
  import cache_assoc_param_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 32,
  parameter int unsigned WAYS        = 4,
  parameter int unsigned SETS        = 32,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input logic                clk,
  input logic                rst,
  cache_assoc_param_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WRD_W = $clog2(BLOCK_WORDS);
  localparam int unsigned AGE_W = $clog2(WAYS);
  localparam int unsigned TAG_W = tag_width(ADDR_BITS, SETS, BLOCK_WORDS);
  localparam int unsigned KEY_W = IDX_W + TAG_W;

  logic [TAG_W-1:0] a_tag;
  logic [IDX_W-1:0] a_idx;
  logic [WRD_W-1:0] a_wrd;
  logic [1:0]       a_byte;
  assign {a_tag, a_idx, a_wrd, a_byte} = bus.addr;

  logic [31:0]      data_q  [SETS][WAYS][BLOCK_WORDS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [AGE_W-1:0] victim_all [SETS];

  state_e           state_q;
  logic [IDX_W-1:0] sweep_idx_q;
  logic [WRD_W-1:0] fill_cnt_q;
  logic [KEY_W-1:0] fill_key_q;
  logic [AGE_W-1:0] vway_q;
  logic             hit_q, out_valid_q, out_dirty_q, fill_done_q, busy_q;
  logic [31:0]      dout_q;
  logic [TAG_W-1:0] out_tag_q;

  logic [AGE_W-1:0] hway, victim, fill_way, touch_way, view_way;
  logic             hit_any, fill_first, fill_last, idle, touch_en;
  logic             do_flush, do_inv, do_store, do_edit, do_load, do_evict;

  always_comb begin
    hit_any = 1'b0;
    hway    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[a_idx][w] && tag_q[a_idx][w] == a_tag) begin
        hit_any = 1'b1;
        hway    = AGE_W'(w);
      end
    end
  end

  assign victim     = victim_all[a_idx];
  assign fill_first = (fill_cnt_q == '0) || (fill_key_q != {a_idx, a_tag});
  assign fill_way   = fill_first ? victim : vway_q;
  assign fill_last  = !fill_first && (fill_cnt_q == '1);

  // One command per cycle in priority order; a running sweep masks everything.
  assign idle     = (state_q == StIdle);
  assign do_flush = idle && bus.flush_all;
  assign do_inv   = idle && !bus.flush_all && bus.invalid;
  assign do_store = idle && !bus.flush_all && !bus.invalid && bus.store;
  assign do_edit  = idle && !bus.flush_all && !bus.invalid && !bus.store && bus.edit && hit_any;
  assign do_load  = idle && !bus.flush_all && !bus.invalid && !bus.store && !bus.edit &&
                    bus.load && hit_any;
  assign do_evict = idle && !bus.flush_all && !bus.invalid && !bus.store && !bus.edit &&
                    bus.evict;

  assign touch_en  = do_edit || do_load || (do_store && fill_last);
  assign touch_way = do_store ? fill_way : hway;
  assign view_way  = (hit_any && !do_evict) ? hway : victim;

  for (genvar s = 0; s < SETS; s++) begin : g_lru
    cache_assoc_param_lru_age_set #(.WAYS(WAYS)) u_lru (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (valid_q[s]),
      .touch_i    (touch_en && (a_idx == IDX_W'(s))),
      .touch_way_i(touch_way),
      .victim_o   (victim_all[s])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sweep_idx_q <= '0;
      fill_cnt_q  <= '0;
      fill_key_q  <= '0;
      vway_q      <= '0;
      hit_q       <= 1'b0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      out_dirty_q <= 1'b0;
      out_tag_q   <= '0;
      fill_done_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      fill_done_q <= 1'b0;
      hit_q       <= hit_any;
      out_valid_q <= valid_q[a_idx][view_way];
      out_dirty_q <= dirty_q[a_idx][view_way];
      out_tag_q   <= tag_q[a_idx][view_way];
      unique case (state_q)
        StSweep: begin
          valid_q[sweep_idx_q] <= '0;
          dirty_q[sweep_idx_q] <= '0;
          fill_cnt_q           <= '0;
          sweep_idx_q          <= sweep_idx_q + IDX_W'(1);
          if (sweep_idx_q == IDX_W'(SETS - 1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          if (do_flush) begin
            state_q     <= StSweep;
            busy_q      <= 1'b1;
            sweep_idx_q <= '0;
            fill_cnt_q  <= '0;
          end else if (do_inv) begin
            valid_q[a_idx] <= '0;
            dirty_q[a_idx] <= '0;
            if (fill_key_q[KEY_W-1 -: IDX_W] == a_idx) fill_cnt_q <= '0;
          end else if (do_store) begin
            data_q[a_idx][fill_way][a_wrd] <= bus.din;
            if (fill_last) begin
              valid_q[a_idx][fill_way] <= 1'b1;
              dirty_q[a_idx][fill_way] <= 1'b0;
              tag_q[a_idx][fill_way]   <= a_tag;
              fill_cnt_q               <= '0;
              fill_done_q              <= 1'b1;
            end else if (fill_first) begin
              fill_cnt_q <= WRD_W'(1);
              fill_key_q <= {a_idx, a_tag};
              vway_q     <= victim;
            end else begin
              fill_cnt_q <= fill_cnt_q + WRD_W'(1);
            end
          end else if (do_edit) begin
            data_q[a_idx][hway][a_wrd] <=
                store_merge(data_q[a_idx][hway][a_wrd], bus.din, a_byte, bus.u_b_h_w);
            dirty_q[a_idx][hway] <= 1'b1;
          end else if (do_load) begin
            dout_q <= load_extract(data_q[a_idx][hway][a_wrd], a_byte, bus.u_b_h_w);
          end else if (do_evict) begin
            dout_q <= data_q[a_idx][victim][a_wrd];
          end
        end
      endcase
    end
  end

  assign bus.hit       = hit_q;
  assign bus.dout      = dout_q;
  assign bus.valid     = out_valid_q;
  assign bus.dirty     = out_dirty_q;
  assign bus.tag       = out_tag_q;
  assign bus.fill_done = fill_done_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_cache_assoc_param.sv
// Directed bench for cache_assoc_param with WAYS=4, SETS=32, BLOCK_WORDS=4.
module tb_cache_assoc_param;
  localparam logic [2:0] Lb = 3'b000, Lw = 3'b010, Lbu = 3'b100;

  logic clk = 1'b0;
  logic rst;
  int   checks_q = 0;
  int   errors_q = 0;

  cache_assoc_param_if #(.ADDR_BITS(32), .SETS(32), .BLOCK_WORDS(4)) bus ();

  cache_assoc_param #(.ADDR_BITS(32), .WAYS(4), .SETS(32), .BLOCK_WORDS(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_q++;
    if (got !== exp) begin
      errors_q++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_cmd();
    bus.load = 1'b0; bus.edit = 1'b0; bus.store = 1'b0; bus.evict = 1'b0;
    bus.invalid = 1'b0; bus.flush_all = 1'b0;
  endtask

  task automatic cmd_load(input logic [31:0] a, input logic [2:0] ubhw);
    bus.addr = a; bus.u_b_h_w = ubhw; bus.load = 1'b1;
    tick(); clear_cmd();
  endtask

  task automatic cmd_edit(input logic [31:0] a, input logic [31:0] d, input logic [2:0] ubhw);
    bus.addr = a; bus.din = d; bus.u_b_h_w = ubhw; bus.edit = 1'b1;
    tick(); clear_cmd();
  endtask

  task automatic cmd_store(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a; bus.din = d; bus.store = 1'b1;
    tick(); clear_cmd();
  endtask

  // Block of tag t in set 0; word k holds t*16+k.
  task automatic fill_set0(input int t);
    for (int k = 0; k < 4; k++) begin
      cmd_store(32'(t << 9) + 32'(4 * k), 32'(t * 16 + k));
      check_val($sformatf("fill_done t%0d w%0d", t, k), 32'(bus.fill_done), 32'(k == 3));
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    clear_cmd();
    bus.addr = '0; bus.din = '0; bus.u_b_h_w = Lw;
    tick(); tick();
    check_val("rst hit", 32'(bus.hit), 0);
    check_val("rst dout", bus.dout, 0);
    check_val("rst valid", 32'(bus.valid), 0);
    check_val("rst dirty", 32'(bus.dirty), 0);
    check_val("rst tag", 32'(bus.tag), 0);
    check_val("rst busy", 32'(bus.busy), 0);
    check_val("rst fill_done", 32'(bus.fill_done), 0);
    rst = 1'b0;

    // Refill block at 0x100 (set 16, tag 0).
    cmd_store(32'h100, 32'h11); check_val("fd1", 32'(bus.fill_done), 0);
    cmd_store(32'h104, 32'h22); check_val("fd2", 32'(bus.fill_done), 0);
    cmd_store(32'h108, 32'h33); check_val("fd3", 32'(bus.fill_done), 0);
    cmd_store(32'h10C, 32'h44); check_val("fd4", 32'(bus.fill_done), 1);
    tick();
    check_val("fd pulse end", 32'(bus.fill_done), 0);
    cmd_load(32'h108, Lw);
    check_val("lw hit", 32'(bus.hit), 1);
    check_val("lw dout", bus.dout, 32'h33);
    check_val("lw dirty", 32'(bus.dirty), 0);

    // Byte edit then signed/unsigned byte loads.
    cmd_edit(32'h101, 32'hAB, Lb);
    cmd_load(32'h101, Lb);
    check_val("lb dout", bus.dout, 32'hFFFF_FFAB);
    check_val("lb dirty", 32'(bus.dirty), 1);
    cmd_load(32'h101, Lbu);
    check_val("lbu dout", bus.dout, 32'h0000_00AB);
    cmd_load(32'h100, Lw);
    check_val("lw merged", bus.dout, 32'h0000_AB11);

    // LRU: tags 1..4 into set 0, touch tag1, fifth fill replaces tag2.
    for (int t = 1; t <= 4; t++) fill_set0(t);
    cmd_load(32'(1 << 9), Lw);
    check_val("touch t1", 32'(bus.hit), 1);
    fill_set0(5);
    cmd_load(32'(1 << 9), Lw);
    check_val("t1 hit", 32'(bus.hit), 1);
    check_val("t1 dout", bus.dout, 32'h10);
    cmd_load(32'(2 << 9) + 32'h4, Lw);
    check_val("t2 miss", 32'(bus.hit), 0);
    check_val("miss dout held", bus.dout, 32'h10);
    for (int t = 3; t <= 5; t++) begin
      cmd_load(32'(t << 9) + 32'h8, Lw);
      check_val($sformatf("t%0d hit", t), 32'(bus.hit), 1);
      check_val($sformatf("t%0d dout", t), bus.dout, 32'(t * 16 + 2));
    end

    // Dirty tag3, then touch tags 1,4,5 so tag3 becomes the victim.
    cmd_edit(32'(3 << 9), 32'hDEAD_BEEF, Lw);
    cmd_load(32'(1 << 9), Lw);
    cmd_load(32'(4 << 9), Lw);
    cmd_load(32'(5 << 9), Lw);
    bus.addr = 32'(6 << 9); bus.evict = 1'b1;
    tick(); clear_cmd();
    check_val("evict dout", bus.dout, 32'hDEAD_BEEF);
    check_val("evict dirty", 32'(bus.dirty), 1);
    check_val("evict valid", 32'(bus.valid), 1);
    check_val("evict tag", 32'(bus.tag), 3);

    // Set invalidate.
    bus.addr = 32'h100; bus.invalid = 1'b1;
    tick(); clear_cmd();
    cmd_load(32'h100, Lw);
    check_val("inv miss", 32'(bus.hit), 0);

    // Flush sweep: busy for exactly SETS cycles.
    bus.flush_all = 1'b1;
    tick(); clear_cmd();
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      cnt++;
      tick();
    end
    check_val("busy cycles", 32'(cnt), 32);
    cmd_load(32'(4 << 9), Lw);
    check_val("flush miss t4", 32'(bus.hit), 0);
    cmd_load(32'(5 << 9), Lw);
    check_val("flush miss t5", 32'(bus.hit), 0);

    // Reset after two refill stores: the remaining two never complete the block.
    cmd_store(32'h300, 32'hA0);
    cmd_store(32'h304, 32'hA1);
    rst = 1'b1;
    tick();
    check_val("mid rst fd", 32'(bus.fill_done), 0);
    check_val("mid rst hit", 32'(bus.hit), 0);
    rst = 1'b0;
    cmd_store(32'h308, 32'hA2); check_val("post rst fd3", 32'(bus.fill_done), 0);
    cmd_store(32'h30C, 32'hA3); check_val("post rst fd4", 32'(bus.fill_done), 0);
    cmd_load(32'h300, Lw);
    check_val("post rst miss", 32'(bus.hit), 0);

    $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
    $finish;
  end
endmodule
